video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Video timing generator that consumes the horizontal and vertical timing fields (sync width, back porch, active, front porch) held in the APB SFR block. It produces hsync, vsync, data-enable and active-pixel coordinates for the downstream pixel pipeline (mirror, blur, weight stages). Timing fields are shadowed at frame boundaries, so APB writes never corrupt a frame in progress.

Parameters:
CW, 16, width of timing fields and internal counters
SYNC_ACT_LOW, 0, 1 makes o_hsync/o_vsync active-low; 0 makes them active-high

Ports:
PCLK  input  1  pixel/APB clock
PRSTN  input  1  reset
i_en  input  1  timing enable level
i_hsw  input  CW  hsync width, in clocks
i_hbp  input  CW  horizontal back porch, in clocks
i_hact  input  CW  active pixels per line
i_hfp  input  CW  horizontal front porch, in clocks
i_vsw  input  CW  vsync width, in lines
i_vbp  input  CW  vertical back porch, in lines
i_vact  input  CW  active lines per frame
i_vfp  input  CW  vertical front porch, in lines
o_hsync  output  1  horizontal sync
o_vsync  output  1  vertical sync
o_de  output  1  data enable (active pixel)
o_x  output  CW  active pixel column, 0..hact-1
o_y  output  CW  active line index, 0..vact-1
o_line_start  output  1  one-clock pulse on the first clock of every line
o_frame_start  output  1  one-clock pulse on the first clock of every frame
o_busy  output  1  high while a frame is in progress

Behaviour:
- Reset PRSTN is asynchronous, active-low; clock is PCLK.
- In reset: all outputs deasserted. Sync outputs go to their inactive level (1 if SYNC_ACT_LOW, else 0). o_x, o_y, pulses, o_de and o_busy are 0. FSMs go to IDLE; shadow registers are cleared.
- All outputs are registered.
- Horizontal FSM: IDLE -> H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC...
  - Each phase lasts exactly its shadow value in clocks.
  - A phase with value 0 is skipped in the same transition.
  - Line length = hsw + hbp + hact + hfp.
- Vertical FSM: IDLE -> V_SYNC -> V_BP -> V_ACT -> V_FP.
  - It advances only on a line boundary: the last clock of the line.
  - Each phase lasts its shadow value in lines; zero-length phases are skipped.
- o_hsync is active during H_SYNC. o_vsync is active for whole lines in V_SYNC and changes only on line boundaries.
- o_de = (H_ACT && V_ACT).
- o_x increments on each o_de clock and resets to 0 at the end of the line. o_y increments after each line in V_ACT. Both hold 0 outside the active region.
- Shadow capture:
  - In IDLE with i_en=1, the edge latches all eight fields.
  - If shadow hact≠0 and vact≠0, that same edge enters frame clock 0: o_frame_start=1, o_line_start=1, o_busy=1. Latency from i_en sampled high to the first frame clock is 1 clock.
  - On the last clock of a frame with i_en=1, fields are re-latched and the next frame starts on the following clock, with no idle gap.
- Invalid timing: if hact==0 or vact==0 at capture time, the block stays in IDLE with outputs inactive. It re-samples every clock while i_en=1.
- i_en deasserted mid-frame: the current frame completes unchanged, then the block returns to IDLE. No further o_frame_start is produced.
- Input field changes mid-frame are ignored until the next frame-boundary capture.
- Arithmetic:
  - Phase counters are CW bits and count down from value-1; no overflow is possible.
  - Maximum fields give a line of up to 4*(2^CW-1) clocks, handled by the per-phase counters.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). After release, the block restarts from IDLE.

Test Plan:
- Basic frame: hsw=2, hbp=3, hact=4, hfp=1, vsw=1, vbp=1, vact=2, vfp=1, i_en=1 -> 50-clock frames with 10-clock lines; 2 hsync clocks per line; 8 de clocks per frame; o_x sequence 0,1,2,3; o_y 0 then 1; o_frame_start every 50 clocks.
- Mid-frame update: change hact 4->6 during line 2 -> current frame stays at 50 clocks; the next frame has 12-clock lines (60 clocks total) and 12 de clocks.
- Zero phases: hbp=0, hfp=0, vfp=0 -> line = hsw+hact; de begins the clock after hsync ends; no front-porch lines; no missed or extra o_line_start.
- Invalid timing: hact=0 with i_en=1 -> o_busy=0 and all outputs inactive for 100 clocks. Writing hact=4 -> frame starts the next clock.
- Disable: drop i_en at frame clock 20 -> frame ends normally at clock 49; o_busy=0 from clock 50; no new o_frame_start.
- Async reset at a de clock -> o_de, o_x and o_busy clear without a clock edge. After release with i_en=1 -> a fresh frame starts with o_frame_start.

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: hsync/vsync/de plus active-pixel coordinates from frame-shadowed timing fields.
// Latency: first frame clock one edge after i_en is sampled high with nonzero hact/vact; all outputs registered.
// Backpressure: none; free-running once started, i_en is only sampled at frame boundaries.
module video_timing_gen #(
    parameter int CW           = 16,
    parameter int SYNC_ACT_LOW = 0
) (
    input  logic          PCLK,
    input  logic          PRSTN,
    input  logic          i_en,
    input  logic [CW-1:0] i_hsw,
    input  logic [CW-1:0] i_hbp,
    input  logic [CW-1:0] i_hact,
    input  logic [CW-1:0] i_hfp,
    input  logic [CW-1:0] i_vsw,
    input  logic [CW-1:0] i_vbp,
    input  logic [CW-1:0] i_vact,
    input  logic [CW-1:0] i_vfp,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_busy
);
    typedef struct packed {
        logic [CW-1:0] hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;
    } timing_t;

    typedef enum logic [2:0] {H_IDLE, H_SYNC, H_BP, H_ACT, H_FP} h_state_t;
    typedef enum logic [2:0] {V_IDLE, V_SYNC, V_BP, V_ACT, V_FP} v_state_t;

    localparam logic SYNC_INACT = (SYNC_ACT_LOW != 0);

    // Horizontal phases wrap; the nearest nonzero phase after p wins. From H_IDLE this is the line's first phase.
    function automatic h_state_t h_after(input h_state_t p, input timing_t t);
        logic [3:0] nz;
        logic [1:0] idx;
        h_state_t   res;
        nz  = {t.hfp != '0, t.hact != '0, t.hbp != '0, t.hsw != '0};
        res = H_ACT;
        for (int k = 4; k >= 1; k--) begin
            idx = 2'(int'(p) - 1 + k);
            if (nz[idx]) res = h_state_t'({1'b0, idx} + 3'd1);
        end
        return res;
    endfunction

    // Vertical phases do not wrap; V_IDLE means the frame is over.
    function automatic v_state_t v_after(input v_state_t p, input timing_t t);
        logic [3:0] nz;
        v_state_t   res;
        nz  = {t.vfp != '0, t.vact != '0, t.vbp != '0, t.vsw != '0};
        res = V_IDLE;
        for (int j = 3; j >= 0; j--) begin
            if (j >= int'(p) && nz[j[1:0]]) res = v_state_t'(3'(j + 1));
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] h_len(input h_state_t p, input timing_t t);
        case (p)
            H_SYNC:  return t.hsw;
            H_BP:    return t.hbp;
            H_ACT:   return t.hact;
            H_FP:    return t.hfp;
            default: return '0;
        endcase
    endfunction

    function automatic logic [CW-1:0] v_len(input v_state_t p, input timing_t t);
        case (p)
            V_SYNC:  return t.vsw;
            V_BP:    return t.vbp;
            V_ACT:   return t.vact;
            V_FP:    return t.vfp;
            default: return '0;
        endcase
    endfunction

    timing_t       sh, sh_n, fields;
    h_state_t      hs, hs_n;
    v_state_t      vs, vs_n;
    logic [CW-1:0] hc, hc_n, vc, vc_n;
    logic          busy, line_end, frame_end, start;
    logic          de_n, line_start_n;
    logic [CW-1:0] x_n, y_n;

    assign fields = '{hsw: i_hsw, hbp: i_hbp, hact: i_hact, hfp: i_hfp,
                      vsw: i_vsw, vbp: i_vbp, vact: i_vact, vfp: i_vfp};
    assign busy   = (hs != H_IDLE);

    always_comb begin
        sh_n      = sh;
        hs_n      = hs;
        hc_n      = hc;
        vs_n      = vs;
        vc_n      = vc;
        start     = 1'b0;
        line_end  = busy && (hc == '0) && (h_after(hs, sh) == h_after(H_IDLE, sh));
        frame_end = line_end && (vc == '0) && (v_after(vs, sh) == V_IDLE);

        if (!busy || frame_end) begin
            if (i_en) begin
                sh_n  = fields;
                start = (i_hact != '0) && (i_vact != '0);
            end
            if (start) begin
                hs_n = h_after(H_IDLE, fields);
                hc_n = h_len(hs_n, fields) - CW'(1);
                vs_n = v_after(V_IDLE, fields);
                vc_n = v_len(vs_n, fields) - CW'(1);
            end else begin
                hs_n = H_IDLE;
                hc_n = '0;
                vs_n = V_IDLE;
                vc_n = '0;
            end
        end else begin
            if (hc == '0) begin
                hs_n = h_after(hs, sh);
                hc_n = h_len(hs_n, sh) - CW'(1);
            end else begin
                hc_n = hc - CW'(1);
            end
            if (line_end) begin
                if (vc == '0) begin
                    vs_n = v_after(vs, sh);
                    vc_n = v_len(vs_n, sh) - CW'(1);
                end else begin
                    vc_n = vc - CW'(1);
                end
            end
        end

        // Coordinates fall out of the down-counters, so no separate x/y state is needed.
        de_n         = (hs_n == H_ACT) && (vs_n == V_ACT);
        x_n          = de_n ? (sh_n.hact - CW'(1) - hc_n) : '0;
        y_n          = (vs_n == V_ACT) ? (sh_n.vact - CW'(1) - vc_n) : '0;
        line_start_n = start || (line_end && !frame_end);
    end

    always_ff @(posedge PCLK or negedge PRSTN) begin
        if (!PRSTN) begin
            sh            <= '0;
            hs            <= H_IDLE;
            hc            <= '0;
            vs            <= V_IDLE;
            vc            <= '0;
            o_hsync       <= SYNC_INACT;
            o_vsync       <= SYNC_INACT;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            sh            <= sh_n;
            hs            <= hs_n;
            hc            <= hc_n;
            vs            <= vs_n;
            vc            <= vc_n;
            o_hsync       <= (hs_n == H_SYNC) ^ SYNC_INACT;
            o_vsync       <= (vs_n == V_SYNC) ^ SYNC_INACT;
            o_de          <= de_n;
            o_x           <= x_n;
            o_y           <= y_n;
            o_line_start  <= line_start_n;
            o_frame_start <= start;
            o_busy        <= (hs_n != H_IDLE);
        end
    end
endmodule
